// File: rtl/rf_write_queue.sv
// rf_write_queue: write-back buffer in front of the 8-bit register file.
// Queues register-write requests in FIFO order, drains one per cycle into
// the register file write port, and supplies newest-pending bypass data
// for the two register file read addresses.
module rf_write_queue #(
  parameter int PW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PW:0]                in_addr,
  input  logic [7:0]                 in_data,
  input  logic                       drain_en,
  output logic                       wr_en,
  output logic [PW:0]                wr_addr,
  output logic [7:0]                 wr_data,
  input  logic [PW-1:0]              rd_addrA,
  input  logic [PW-1:0]              rd_addrB,
  output logic                       hitA,
  output logic [7:0]                 bypA,
  output logic                       hitB,
  output logic [7:0]                 bypB,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW:0]   mem_addr [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;
  logic [AW-1:0] idx;

  // A freshly pushed entry is not visible to the pop until the next edge,
  // so pop looks only at the registered count.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = drain_en && (count != '0);

  // Entry storage is written on accepted requests and never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= in_addr;
      mem_data[tail] <= in_data;
    end
  end

  // Pointers, occupancy, output register and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head    <= head + 1'b1;
        wr_en   <= 1'b1;
        wr_addr <= mem_addr[head];
        wr_data <= mem_data[head];
      end else begin
        wr_en <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Bypass search: start from the output register, then walk the queue
  // from oldest to newest so the newest matching entry wins.
  always_comb begin
    hitA = 1'b0;
    bypA = 8'h00;
    hitB = 1'b0;
    bypB = 8'h00;
    idx  = '0;
    if (wr_en && (wr_addr == {1'b0, rd_addrA})) begin
      hitA = 1'b1;
      bypA = wr_data;
    end
    if (wr_en && (wr_addr == {1'b0, rd_addrB})) begin
      hitB = 1'b1;
      bypB = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if (mem_addr[idx] == {1'b0, rd_addrA}) begin
          hitA = 1'b1;
          bypA = mem_data[idx];
        end
        if (mem_addr[idx] == {1'b0, rd_addrB}) begin
          hitB = 1'b1;
          bypB = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue: directed and random stimulus against a queue-based
// reference model; drained writes are checked by a separate monitor.
module tb_rf_write_queue;

  localparam int PW    = 3;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [PW:0]  in_addr = '0;
  logic [7:0]   in_data = '0;
  logic         drain_en = 1'b0;
  logic         wr_en;
  logic [PW:0]  wr_addr;
  logic [7:0]   wr_data;
  logic [PW-1:0] rd_addrA = '0;
  logic [PW-1:0] rd_addrB = '0;
  logic         hitA;
  logic [7:0]   bypA;
  logic         hitB;
  logic [7:0]   bypB;
  logic [$clog2(DEPTH):0] count;
  logic         overflow;

  typedef struct packed {
    logic [PW:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t mq[$];
  req_t sb[$];
  req_t mLast;
  req_t monE;
  logic mWrValid = 1'b0;
  logic mOverflow = 1'b0;
  int   total = 0;
  int   bad = 0;

  rf_write_queue #(.PW(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .hitA(hitA), .bypA(bypA), .hitB(hitB), .bypB(bypB),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest pending write for a read address, from the model's view.
  task automatic modelByp(input logic [PW-1:0] ra, output int h, output int d);
    h = 0;
    d = 0;
    if (mWrValid && mLast.addr == {1'b0, ra}) begin
      h = 1;
      d = int'(mLast.data);
    end
    foreach (mq[i]) begin
      if (mq[i].addr == {1'b0, ra}) begin
        h = 1;
        d = int'(mq[i].data);
      end
    end
  endtask

  task automatic checkState();
    int h;
    int d;
    checkOutput("count", int'(count), mq.size());
    checkOutput("in_ready", int'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
    checkOutput("overflow", int'(overflow), int'(mOverflow));
    checkOutput("wr_en", int'(wr_en), int'(mWrValid));
    modelByp(rd_addrA, h, d);
    checkOutput("hitA", int'(hitA), h);
    checkOutput("bypA", int'(bypA), d);
    modelByp(rd_addrB, h, d);
    checkOutput("hitB", int'(hitB), h);
    checkOutput("bypB", int'(bypB), d);
  endtask

  // One clock cycle: drive inputs after a falling edge, advance the model
  // at the rising edge, check state at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [PW:0] a,
                               input logic [7:0] dt, input logic dr);
    logic doPush;
    logic doPop;
    logic doOvf;
    in_valid = v;
    in_addr  = a;
    in_data  = dt;
    drain_en = dr;
    doPush = v && (mq.size() < DEPTH);
    doOvf  = v && !(mq.size() < DEPTH);
    doPop  = dr && (mq.size() > 0);
    @(posedge clk);
    if (doPop) begin
      mLast = mq.pop_front();
      sb.push_back(mLast);
      mWrValid = 1'b1;
    end else begin
      mWrValid = 1'b0;
    end
    if (doPush) mq.push_back({a, dt});
    if (doOvf) mOverflow = 1'b1;
    @(negedge clk);
    checkState();
  endtask

  // Monitor: every write strobe must match the oldest expected drain.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_drain actual=%0h:%0h expected=none", wr_addr, wr_data);
      end else begin
        monE = sb.pop_front();
        checkOutput("drain_addr", int'(wr_addr), int'(monE.addr));
        checkOutput("drain_data", int'(wr_data), int'(monE.data));
      end
    end
  end

  initial begin
    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkState();

    // Single write with drain enabled, bypass on A
    rd_addrA = 3'd3;
    rd_addrB = 3'd0;
    applyStimulus(1'b1, 4'd3, 8'hA5, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);

    // Fill, overflow, then drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(i + 1), 8'(8'h10 + i), 1'b0);
    applyStimulus(1'b1, 4'd6, 8'hEE, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);

    // Duplicate address: newest wins
    rd_addrB = 3'd2;
    applyStimulus(1'b1, 4'd2, 8'h11, 1'b0);
    applyStimulus(1'b1, 4'd2, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);

    // Simultaneous push/pop at count=2, pointers wrap
    applyStimulus(1'b1, 4'd1, 8'h31, 1'b0);
    applyStimulus(1'b1, 4'd5, 8'h32, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 4'(i + 8), 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);

    // Async reset mid-drain
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'(i), 8'(8'h50 + i), 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_wr_en", int'(wr_en), 0);
    checkOutput("async_count", int'(count), 0);
    checkOutput("async_overflow", int'(overflow), 0);
    mq.delete();
    sb.delete();
    mWrValid  = 1'b0;
    mOverflow = 1'b0;
    drain_en  = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_addrA = 3'd5;
    applyStimulus(1'b1, 4'd5, 8'h7E, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rd_addrA = 3'($urandom_range(0, 7));
      rd_addrB = 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Write-back buffer directly upstream of the 8-bit register file.
- Accepts register-write requests (address, data) from the execute stage over a valid/ready handshake and queues them in FIFO order.
- Drains one request per cycle into the register file's single write port (wr_en / wr_addr / dat_in) whenever the drain is enabled.
- Provides same-cycle bypass data for the register file's two read addresses while writes are still pending, so consumers never read stale data.

Parameters:
PW, 3, register address width; write address is PW+1 bits, read addresses are PW bits
DEPTH, 4, queue entries; power of two, minimum 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute stage presents a write request
in_ready  output  1  queue can accept a request this cycle
in_addr  input  PW+1  destination register of the request
in_data  input  8  data to be written
drain_en  input  1  register-file write port available this cycle
wr_en  output  1  registered write strobe to register file
wr_addr  output  PW+1  registered write address to register file
wr_data  output  8  registered write data (drives register file dat_in)
rd_addrA  input  PW  register file read address A (snooped)
rd_addrB  input  PW  register file read address B (snooped)
hitA  output  1  pending write matches rd_addrA
bypA  output  8  newest pending data for rd_addrA; 0 when no hit
hitB  output  1  pending write matches rd_addrB
bypB  output  8  newest pending data for rd_addrB; 0 when no hit
count  output  $clog2(DEPTH)+1  entries currently queued
overflow  output  1  sticky: request offered while not ready

Behaviour:
- Reset (rst_n low, asynchronous): count=0, head/tail pointers=0, wr_en=0, wr_addr=0, wr_data=0, overflow=0. Entry storage is not cleared.
- Reset asserted mid-operation discards all queued and in-flight writes. wr_en must drop immediately, without waiting for a clock edge.
- in_ready = (count < DEPTH). It is combinational from count only; there is no pass-through when full, even if a pop occurs in the same cycle.
- Enqueue on an edge where in_valid && in_ready: entry[tail] <= {in_addr, in_data}; tail increments mod DEPTH.
- Pop on an edge where drain_en && count>0:
  - wr_en<=1, wr_addr<=entry[head].addr, wr_data<=entry[head].data.
  - head increments mod DEPTH.
- If there is no pop on an edge, wr_en<=0; wr_addr and wr_data hold their values.
- Simultaneous push and pop: count unchanged; both pointers advance. With count==0, a push and drain_en on the same edge does not pop, since the entry is not yet visible.
- Latency: a request accepted at edge k is popped at earliest edge k+1 (wr_en high during cycle k+1..k+2). The register file commits it at edge k+2.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- Overflow: in_valid && !in_ready on any edge sets overflow=1. The request is dropped and queue state is unchanged. overflow clears only on reset.
- Bypass (combinational):
  - Candidates are the valid queue entries plus the output register when wr_en=1.
  - Match condition: candidate addr == {1'b0, rd_addrX}, i.e. the read address zero-extended.
  - Priority runs newest first: the entry nearest tail, then older entries toward head, then the output register.
  - A request being presented on in_* this cycle is not a candidate.
  - hitX=0 implies bypX=8'h00.
- Duplicate addresses in the queue are legal. Writes drain in order and the bypass returns the newest matching entry.
- Entries with addr MSB=1 (upper half of the write address space) never produce a bypass hit.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release -> count=0, in_ready=1, wr_en=0, hitA=hitB=0, overflow=0.
- Single write, drain_en=1: push {addr=3, data=8'hA5} at edge 1 -> wr_en=1, wr_addr=3, wr_data=A5 after edge 2; wr_en=0 after edge 3. Meanwhile rd_addrA=3 -> hitA=1, bypA=A5 from edge 1 until edge 3.
- Fill and overflow with drain_en=0:
  - Push 4 requests addr 1..4, data 10..13 -> count=4, in_ready=0.
  - 5th push -> dropped, overflow=1, count=4.
  - Raise drain_en -> wr_addr sequence 1,2,3,4 on consecutive cycles.
- Duplicate address priority: push {2,8'h11} then {2,8'h22}, drain_en=0, rd_addrB=2 -> hitB=1, bypB=22. Enable drain -> wr_data 11 then 22, and bypB stays 22 until the second write leaves the output register.
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2, head/tail wrap past DEPTH, drained order matches pushed order exactly.
- Async reset mid-drain: count=3, wr_en=1, assert rst_n low between edges -> wr_en=0 and count=0 without a clock edge; post-release push {5,8'h7E} drains normally.
